// File: rtl/fp_adder_stage1_if.sv
// Operand/result bundle between the add0 (unpack input) and add1 (aligned output)
// stages of the floating-point adder.
interface fp_adder_stage1_if;
    logic        add0_valid;
    logic [31:0] add0_operand1;
    logic [31:0] add0_operand2;
    logic        add0_subtract;

    logic        add1_valid;
    logic [5:0]  add1_operand_align_shift;
    logic [25:0] add1_significand1;
    logic [25:0] add1_significand2;
    logic [7:0]  add1_exponent1;
    logic [7:0]  add1_exponent2;
    logic        add1_exponent2_larger;
    logic        add1_result_is_nan;
    logic        add1_result_is_inf;
    logic        add1_result_inf_sign;

    modport master (
        output add0_valid, add0_operand1, add0_operand2, add0_subtract,
        input  add1_valid, add1_operand_align_shift, add1_significand1,
               add1_significand2, add1_exponent1, add1_exponent2,
               add1_exponent2_larger, add1_result_is_nan, add1_result_is_inf,
               add1_result_inf_sign
    );

    modport slave (
        input  add0_valid, add0_operand1, add0_operand2, add0_subtract,
        output add1_valid, add1_operand_align_shift, add1_significand1,
               add1_significand2, add1_exponent1, add1_exponent2,
               add1_exponent2_larger, add1_result_is_nan, add1_result_is_inf,
               add1_result_inf_sign
    );
endinterface

// File: rtl/fp_adder_stage1.sv
// fp_adder_stage1: unpack two IEEE single operands, order them by exponent,
// convert significands to two's complement and compute the saturated alignment
// shift for stage 2. Single register stage, held by stall, async active-high reset.
// Optional build macro FP_ADDER_SPECIAL_CASE_EN adds NaN/infinity detection;
// without it the special-case flags are tied to 0.
module fp_adder_stage1 (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    fp_adder_stage1_if.slave   bus
);
    localparam int          EXP_W     = 8;
    localparam int          FRAC_W    = 23;
    localparam int          SIG_W     = FRAC_W + 3;
    localparam logic [5:0]  SHIFT_MAX = 6'd27;

    logic [EXP_W-1:0]  raw_exp1, raw_exp2;
    logic [EXP_W-1:0]  eff_exp1, eff_exp2;
    logic [FRAC_W-1:0] frac1, frac2;
    logic              sign1, sign2;
    logic [SIG_W-1:0]  mag1, mag2, sig1_tc, sig2_tc;
    logic              exp2_larger;
    logic [EXP_W:0]    exp_diff;
    logic [5:0]        shift;

    logic              valid_d, valid_q;
    logic [5:0]        shift_d, shift_q;
    logic [SIG_W-1:0]  sig1_d, sig1_q, sig2_d, sig2_q;
    logic [EXP_W-1:0]  exp1_d, exp1_q, exp2_d, exp2_q;
    logic              exp2_larger_d, exp2_larger_q;

    // Unpack, sign-convert, compare exponents and saturate the shift amount.
    always_comb begin
        raw_exp1 = bus.add0_operand1[30:23];
        raw_exp2 = bus.add0_operand2[30:23];
        frac1    = bus.add0_operand1[22:0];
        frac2    = bus.add0_operand2[22:0];
        sign1    = bus.add0_operand1[31];
        sign2    = bus.add0_operand2[31] ^ bus.add0_subtract;

        // Denormals share the exponent of the smallest normal but lack the hidden bit.
        eff_exp1 = (raw_exp1 == '0) ? EXP_W'(1) : raw_exp1;
        eff_exp2 = (raw_exp2 == '0) ? EXP_W'(1) : raw_exp2;
        mag1     = {2'b00, (raw_exp1 != '0), frac1};
        mag2     = {2'b00, (raw_exp2 != '0), frac2};
        sig1_tc  = sign1 ? (SIG_W'(0) - mag1) : mag1;
        sig2_tc  = sign2 ? (SIG_W'(0) - mag2) : mag2;

        exp2_larger = eff_exp2 > eff_exp1;
        exp_diff    = exp2_larger ? ({1'b0, eff_exp2} - {1'b0, eff_exp1})
                                  : ({1'b0, eff_exp1} - {1'b0, eff_exp2});
        // Beyond 27 places everything is sticky-only, so a larger shift is pointless.
        shift       = (exp_diff >= 9'd27) ? SHIFT_MAX : exp_diff[5:0];
    end

    // Next-state for the output registers: hold on stall, otherwise load.
    always_comb begin
        valid_d       = valid_q;
        shift_d       = shift_q;
        sig1_d        = sig1_q;
        sig2_d        = sig2_q;
        exp1_d        = exp1_q;
        exp2_d        = exp2_q;
        exp2_larger_d = exp2_larger_q;
        if (!stall) begin
            valid_d       = bus.add0_valid;
            shift_d       = shift;
            sig1_d        = exp2_larger ? sig2_tc : sig1_tc;
            sig2_d        = exp2_larger ? sig1_tc : sig2_tc;
            exp1_d        = eff_exp1;
            exp2_d        = eff_exp2;
            exp2_larger_d = exp2_larger;
        end
    end

    // Output register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            shift_q       <= '0;
            sig1_q        <= '0;
            sig2_q        <= '0;
            exp1_q        <= '0;
            exp2_q        <= '0;
            exp2_larger_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            shift_q       <= shift_d;
            sig1_q        <= sig1_d;
            sig2_q        <= sig2_d;
            exp1_q        <= exp1_d;
            exp2_q        <= exp2_d;
            exp2_larger_q <= exp2_larger_d;
        end
    end

    assign bus.add1_valid               = valid_q;
    assign bus.add1_operand_align_shift = shift_q;
    assign bus.add1_significand1        = sig1_q;
    assign bus.add1_significand2        = sig2_q;
    assign bus.add1_exponent1           = exp1_q;
    assign bus.add1_exponent2           = exp2_q;
    assign bus.add1_exponent2_larger    = exp2_larger_q;

`ifdef FP_ADDER_SPECIAL_CASE_EN
    logic is_nan1, is_nan2, is_inf1, is_inf2;
    logic nan_d, nan_q, inf_d, inf_q, inf_sign_d, inf_sign_q;

    // Classify operands and derive the special-case result flags.
    always_comb begin
        is_nan1    = (raw_exp1 == '1) && (frac1 != '0);
        is_nan2    = (raw_exp2 == '1) && (frac2 != '0);
        is_inf1    = (raw_exp1 == '1) && (frac1 == '0);
        is_inf2    = (raw_exp2 == '1) && (frac2 == '0);
        nan_d      = nan_q;
        inf_d      = inf_q;
        inf_sign_d = inf_sign_q;
        if (!stall) begin
            // inf - inf (after sign folding) has no defined result.
            nan_d      = is_nan1 || is_nan2 || (is_inf1 && is_inf2 && (sign1 != sign2));
            inf_d      = !nan_d && (is_inf1 || is_inf2);
            inf_sign_d = is_inf1 ? sign1 : sign2;
        end
    end

    // Special-case flag registers, same hold/reset behaviour as the data path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            inf_sign_q <= 1'b0;
        end else begin
            nan_q      <= nan_d;
            inf_q      <= inf_d;
            inf_sign_q <= inf_sign_d;
        end
    end

    assign bus.add1_result_is_nan   = nan_q;
    assign bus.add1_result_is_inf   = inf_q;
    assign bus.add1_result_inf_sign = inf_sign_q;
`else
    assign bus.add1_result_is_nan   = 1'b0;
    assign bus.add1_result_is_inf   = 1'b0;
    assign bus.add1_result_inf_sign = 1'b0;
`endif
endmodule

// File: tb/tb_fp_adder_stage1.sv
// Bench for fp_adder_stage1: directed literal cases, stall/reset scenarios and
// randomized operands checked every cycle against an arithmetic reference model.
module tb_fp_adder_stage1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic check_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    fp_adder_stage1_if bus ();

    fp_adder_stage1 dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int valid, shift, sig1, sig2, exp1, exp2, e2l, nan, inf, isign;
    } exp_t;

    exp_t expd = '{default: 0};

    // Reference: what add1_* must be for given operands, from plain arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic v);
        exp_t r;
        int e1, e2, f1, f2, s1, s2, ee1, ee2, m1, m2, v1, v2, diff;
        int nan1, nan2, inf1, inf2;
        e1 = int'(a[30:23]); f1 = int'(a[22:0]); s1 = int'(a[31]);
        e2 = int'(b[30:23]); f2 = int'(b[22:0]); s2 = int'(b[31] ^ sub);
        ee1 = (e1 == 0) ? 1 : e1;
        ee2 = (e2 == 0) ? 1 : e2;
        m1 = f1 + ((e1 != 0) ? 8388608 : 0);
        m2 = f2 + ((e2 != 0) ? 8388608 : 0);
        v1 = (s1 != 0) ? -m1 : m1;
        v2 = (s2 != 0) ? -m2 : m2;
        v1 = v1 & 32'h03FF_FFFF;
        v2 = v2 & 32'h03FF_FFFF;
        diff = (ee1 > ee2) ? ee1 - ee2 : ee2 - ee1;
        r.valid = int'(v);
        r.shift = (diff > 27) ? 27 : diff;
        r.exp1 = ee1;
        r.exp2 = ee2;
        r.e2l = (ee2 > ee1) ? 1 : 0;
        r.sig1 = (ee2 > ee1) ? v2 : v1;
        r.sig2 = (ee2 > ee1) ? v1 : v2;
        r.nan = 0; r.inf = 0; r.isign = 0;
`ifdef FP_ADDER_SPECIAL_CASE_EN
        nan1 = (e1 == 255 && f1 != 0) ? 1 : 0;
        nan2 = (e2 == 255 && f2 != 0) ? 1 : 0;
        inf1 = (e1 == 255 && f1 == 0) ? 1 : 0;
        inf2 = (e2 == 255 && f2 == 0) ? 1 : 0;
        r.nan = (nan1 == 1 || nan2 == 1 || (inf1 == 1 && inf2 == 1 && s1 != s2)) ? 1 : 0;
        r.inf = (r.nan == 0 && (inf1 == 1 || inf2 == 1)) ? 1 : 0;
        r.isign = (inf1 == 1) ? s1 : s2;
`else
        nan1 = 0; nan2 = 0; inf1 = 0; inf2 = 0;
`endif
        return r;
    endfunction

    // Model register: reset clears, stall holds, otherwise load from inputs.
    always @(posedge clk or posedge reset) begin
        if (reset)
            expd = '{default: 0};
        else if (!stall)
            expd = model(bus.add0_operand1, bus.add0_operand2, bus.add0_subtract,
                         bus.add0_valid);
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("valid", int'(bus.add1_valid), e.valid);
        chk("shift", int'(bus.add1_operand_align_shift), e.shift);
        chk("sig1", int'(bus.add1_significand1), e.sig1);
        chk("sig2", int'(bus.add1_significand2), e.sig2);
        chk("exp1", int'(bus.add1_exponent1), e.exp1);
        chk("exp2", int'(bus.add1_exponent2), e.exp2);
        chk("exp2_larger", int'(bus.add1_exponent2_larger), e.e2l);
        chk("is_nan", int'(bus.add1_result_is_nan), e.nan);
        chk("is_inf", int'(bus.add1_result_is_inf), e.inf);
        chk("inf_sign", int'(bus.add1_result_inf_sign), e.isign);
    endtask

    // Per-cycle compare against the model, away from the clock edge.
    always @(posedge clk) begin
        #1;
        if (check_en && !reset) chk_all(expd);
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic v, input logic st);
        @(negedge clk);
        bus.add0_operand1 = a;
        bus.add0_operand2 = b;
        bus.add0_subtract = sub;
        bus.add0_valid    = v;
        stall             = st;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int sel;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0: e = 8'd0;
            1: e = 8'd255;
            2: e = 8'd254;
            3: e = 8'd1;
            4: e = 8'(127 + int'($urandom_range(0, 6)) - 3);
            default: e = 8'($urandom);
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    initial begin
        bus.add0_operand1 = '0;
        bus.add0_operand2 = '0;
        bus.add0_subtract = 1'b0;
        bus.add0_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", int'(bus.add1_valid), 0);
        chk("reset_sig1", int'(bus.add1_significand1), 0);
        chk("reset_exp1", int'(bus.add1_exponent1), 0);
        @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;

        // 1.0 + 2.0
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t1_e2l", int'(bus.add1_exponent2_larger), 1);
        chk("t1_shift", int'(bus.add1_operand_align_shift), 1);
        chk("t1_exp1", int'(bus.add1_exponent1), 127);
        chk("t1_exp2", int'(bus.add1_exponent2), 128);
        chk("t1_sig1", int'(bus.add1_significand1), 32'h0080_0000);
        chk("t1_sig2", int'(bus.add1_significand2), 32'h0080_0000);
        chk("t1_valid", int'(bus.add1_valid), 1);

        // 3.0 - 1.0
        drive(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b0);
        settle();
        chk("t2_e2l", int'(bus.add1_exponent2_larger), 0);
        chk("t2_shift", int'(bus.add1_operand_align_shift), 1);
        chk("t2_sig1", int'(bus.add1_significand1), 32'h00C0_0000);
        chk("t2_sig2", int'(bus.add1_significand2), 32'h0380_0000);

        // Saturated shift
        drive(32'h7F00_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t3_shift", int'(bus.add1_operand_align_shift), 27);
        chk("t3_exp1", int'(bus.add1_exponent1), 254);
        chk("t3_exp2", int'(bus.add1_exponent2), 127);

        // Denormal + zero
        drive(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t4_exp1", int'(bus.add1_exponent1), 1);
        chk("t4_exp2", int'(bus.add1_exponent2), 1);
        chk("t4_shift", int'(bus.add1_operand_align_shift), 0);
        chk("t4_sig1", int'(bus.add1_significand1), 1);

        // +inf + -inf, then +inf - 1.0
        drive(32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b1, 1'b0);
        settle();
`ifdef FP_ADDER_SPECIAL_CASE_EN
        chk("t5_nan", int'(bus.add1_result_is_nan), 1);
        chk("t5_inf", int'(bus.add1_result_is_inf), 0);
`else
        chk("t5_nan", int'(bus.add1_result_is_nan), 0);
        chk("t5_inf", int'(bus.add1_result_is_inf), 0);
`endif
        drive(32'h7F80_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b0);
        settle();
`ifdef FP_ADDER_SPECIAL_CASE_EN
        chk("t6_inf", int'(bus.add1_result_is_inf), 1);
`else
        chk("t6_inf", int'(bus.add1_result_is_inf), 0);
`endif
        chk("t6_inf_sign", int'(bus.add1_result_inf_sign), 0);
        chk("t6_nan", int'(bus.add1_result_is_nan), 0);

        // Stall holds: load 1.0+2.0, then 3 stalled cycles with new operands, valid low
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h4040_0000 + 32'(i), 32'hC1A0_0000, 1'b1, 1'b0, 1'b1);
            settle();
            chk("stall_valid", int'(bus.add1_valid), 1);
            chk("stall_sig1", int'(bus.add1_significand1), 32'h0080_0000);
            chk("stall_exp2", int'(bus.add1_exponent2), 128);
        end
        drive(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 1'b0);
        settle();
        chk("post_stall_sig2", int'(bus.add1_significand2), 32'h0380_0000);

        // Reset mid-stream during a stall: asynchronous clear
        drive(32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", int'(bus.add1_valid), 0);
        chk("async_rst_sig1", int'(bus.add1_significand1), 0);
        chk("async_rst_exp1", int'(bus.add1_exponent1), 0);
        @(negedge clk);
        reset = 1'b0;
        settle();
        chk("rst_stall_hold", int'(bus.add1_valid), 0);
        drive(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        settle();
        chk("rst_first_load", int'(bus.add1_exponent2), 128);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(rand_op(), rand_op(), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0));
            if (i == 200) begin
                #2;
                reset = 1'b1;
                #1;
                chk("rand_rst_valid", int'(bus.add1_valid), 0);
                #1;
                reset = 1'b0;
            end
        end
        settle();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fp_adder_stage1.md
# fp_adder_stage1

First stage of the floating-point addition pipeline. Unpacks two IEEE-754 single-precision operands and applies the add/subtract operation to the sign of operand 2. Compares exponents, swaps significands so the larger-exponent operand is always significand1, and converts both significands to two's complement. Computes the saturated alignment shift that feeds fp_adder_stage2, which selects the result exponent and performs the arithmetic right shift.

## Interface
Parameters:
- None. Widths come from `FP_EXPONENT_WIDTH` (8) and `FP_SIGNIFICAND_WIDTH` (23); operand width is 32.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold all output registers this cycle
- add0_valid  in  1  operands present
- add0_operand1  in  32  IEEE single, operand 1
- add0_operand2  in  32  IEEE single, operand 2
- add0_subtract  in  1  1 = operand1 − operand2
- add1_valid  out  1  registered add0_valid
- add1_operand_align_shift  out  6  right shift for significand2, saturated
- add1_significand1  out  26  two's complement, larger-exponent operand
- add1_significand2  out  26  two's complement, smaller-exponent operand, unshifted
- add1_exponent1  out  8  effective exponent of operand1, not swapped
- add1_exponent2  out  8  effective exponent of operand2, not swapped
- add1_exponent2_larger  out  1  exponent2 > exponent1, strict
- add1_result_is_nan  out  1  special case: NaN result
- add1_result_is_inf  out  1  special case: infinite result
- add1_result_inf_sign  out  1  sign of infinite result

## Operation
Unpack:
- Raw exponent E, fraction F, sign S.
- Effective exponent = (E==0) ? 1 : E.
- Hidden bit = (E != 0).

Effective sign:
- s1 = S1.
- s2 = S2 ^ add0_subtract.

Magnitude and sign conversion:
- Magnitude m = {2'b00, hidden, F}, 26 bits: bit 25 sign, bit 24 headroom, bit 23 hidden.
- Signed value = s ? (−m mod 2^26) : m.

Exponent compare:
- exponent2_larger = eff_exp2 > eff_exp1.
- If 1: significand1 = signed op2 and significand2 = signed op1.
- Else no swap.
- Equal exponents → no swap, shift 0.

Alignment shift:
- diff = |eff_exp1 − eff_exp2|, computed at 9 bits.
- shift = min(diff, 27).
- Any diff ≥ 27 reports exactly 27.

Exponent outputs:
- Always report the unswapped effective exponents.
- Stage 2 selects the larger one using exponent2_larger.

Register update:
- When stall=0: all registers load their next values and add1_valid <= add0_valid.
- Data registers load regardless of add0_valid.

## Timing
- Latency: 1 cycle, add0_* → add1_*.
- Stall: stall=1 holds every output, including add1_valid, unchanged. Operands presented during a stall are dropped; the upstream stage is responsible for holding them.
- Reset: every output resets to 0. Reset overrides stall. Reset asserted mid-stream clears add1_valid immediately, asynchronously. The first load after deassertion is the first clk edge with stall=0.
- Throughput: one operation per unstalled cycle; no internal state beyond the output registers.

## Configuration
`FP_ADDER_SPECIAL_CASE_EN` defined:
- is_nan = either operand NaN (E=255, F≠0), or both infinite with s1 ≠ s2.
- is_inf = not is_nan and at least one operand infinite.
- inf_sign = effective sign of the infinite operand; s1 when both are infinite.
- All three flags are registered with the same stall/reset behaviour as the data path.

Not defined:
- add1_result_is_nan, add1_result_is_inf and add1_result_inf_sign are constant 0.
- No special-case logic is synthesized.
- The data path is identical in both builds.

## Test plan
- 0x3F800000 + 0x40000000, add, valid → next cycle: exponent2_larger=1, shift=1, exponent1=127, exponent2=128, significand1=0x0800000, significand2=0x0800000, valid=1.
- 0x40400000 − 0x3F800000 → exponent2_larger=0, shift=1, significand1=0x0C00000, significand2=0x3800000.
- 0x7F000000 + 0x3F800000 → shift=27 (saturated), exponent1=254, exponent2=127. Denormal 0x00000001 + 0x00000000 → both exponents=1, shift=0, significand1=0x0000001.
- 0x7F800000 + 0xFF800000 with the macro defined → is_nan=1, is_inf=0. 0x7F800000 − 0x3F800000 → is_inf=1, inf_sign=0. With the macro undefined → all flags 0.
- Load one operation, then stall=1 for 3 cycles while changing operands and dropping add0_valid → outputs and add1_valid=1 unchanged; first cycle after stall=0 reflects the new inputs.
- Reset pulsed mid-stream, including during a stall → all outputs 0 immediately. After release, the first unstalled edge loads normally.
